reflet_bus_arbiter16: RTL and testbench

Two-master arbiter for the 16-bit Reflet system bus, sharing one bus between the CPU (master 0) and a second requester such as a DMA engine or debug loader (master 1). The shared bus feeds the instruction RAM, data RAM and peripheral block. The arbiter grants ownership round-robin with a bounded burst length and routes one-cycle-latency read data back to the master that issued the read. It sits between the masters and the bus-address decode.

---
 rtl/reflet_bus_arbiter16.sv | 170 +++++++++++++++++
 tb/tb_reflet_bus_arbiter16.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reflet_bus_arbiter16.sv
// reflet_bus_arbiter16: two-master round-robin arbiter for the 16-bit Reflet system bus.
//
// Master 0 (CPU) and master 1 (DMA / debug loader) share one bus. Ownership is granted
// round-robin with a bounded burst while the other master waits. Read data, valid one
// cycle after the address, is steered back to the master that issued the read.
//
// Optional feature: define REFLET_ARBITER_LOCK_EN to add m0_lock / m1_lock. While the
// current owner holds its lock, it keeps the bus regardless of burst limit or req.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   mX_req, mX_addr, mX_data_out,   master X request, byte address, write data,
//   mX_write_en                     write (1) / read (0)
//   mX_lock                         (lock build only) hold ownership while owner
//   mX_gnt                          master X owns the bus this cycle
//   mX_data_in                      read data returned to master X
//   bus_addr, bus_data_out,         shared bus address, write data, write strobe
//   bus_write_en
//   bus_data_in                     OR-combined read data, one cycle after address
//   bus_owner                       current owner index (valid while a gnt is high)

module reflet_bus_arbiter16 #(
  parameter int unsigned wordsize  = 16,
  parameter int unsigned burst_max = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_data_out,
  input  logic                m0_write_en,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_data_out,
  input  logic                m1_write_en,
`ifdef REFLET_ARBITER_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  output logic                m0_gnt,
  output logic                m1_gnt,
  output logic [wordsize-1:0] m0_data_in,
  output logic [wordsize-1:0] m1_data_in,
  output logic [wordsize-1:0] bus_addr,
  output logic [wordsize-1:0] bus_data_out,
  output logic                bus_write_en,
  input  logic [wordsize-1:0] bus_data_in,
  output logic                bus_owner
);

  localparam logic [3:0] BurstMax = 4'(burst_max);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;          // 1: favour m1 on a tie, 0: favour m0
  logic [3:0] cnt_q, cnt_d;          // transfers made while the other master waits
  logic       tag_valid_q, tag_valid_d;
  logic       tag_who_q, tag_who_d;

  logic       owned, own1;
  logic       owner_req, other_req, owner_we;
  logic       xfer, locked, burst_hit;
  logic [3:0] cnt_inc;
  state_e     other_st;

  assign owned     = (state_q != StIdle);
  assign own1      = (state_q == StOwn1);
  assign owner_req = own1 ? m1_req : m0_req;
  assign other_req = own1 ? m0_req : m1_req;
  assign owner_we  = own1 ? m1_write_en : m0_write_en;
  assign xfer      = owned & owner_req;
  assign other_st  = own1 ? StOwn0 : StOwn1;

`ifdef REFLET_ARBITER_LOCK_EN
  assign locked = owned & (own1 ? m1_lock : m0_lock);
`else
  assign locked = 1'b0;
`endif

  // Saturating so a long locked sequence cannot wrap; the limit then fires on the first
  // unlocked transfer.
  assign cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign burst_hit = (cnt_inc >= BurstMax);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          state_d = ptr_q ? StOwn1 : StOwn0;
        end else if (m0_req) begin
          state_d = StOwn0;
        end else if (m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (!locked) begin
          if (!owner_req) begin
            state_d = other_req ? other_st : StIdle;
          end else if (other_req && burst_hit) begin
            state_d = other_st;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || !owned || !other_req) begin
      cnt_d = 4'd0;
    end else if (xfer) begin
      cnt_d = cnt_inc;
    end
  end

  // Point away from whichever master just took the bus.
  always_comb begin
    ptr_d = ptr_q;
    if (state_d != state_q) begin
      if (state_d == StOwn0) begin
        ptr_d = 1'b1;
      end else if (state_d == StOwn1) begin
        ptr_d = 1'b0;
      end
    end
  end

  // Rewritten every cycle so a write or idle cycle retires the previous read.
  assign tag_valid_d = xfer & ~owner_we;
  assign tag_who_d   = own1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
      tag_valid_q <= 1'b0;
      tag_who_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_who_q   <= tag_who_d;
    end
  end

  assign m0_gnt    = (state_q == StOwn0);
  assign m1_gnt    = own1;
  assign bus_owner = own1;

  always_comb begin
    bus_addr     = '0;
    bus_data_out = '0;
    bus_write_en = 1'b0;
    if (owned) begin
      bus_addr     = own1 ? m1_addr : m0_addr;
      bus_data_out = own1 ? m1_data_out : m0_data_out;
      bus_write_en = owner_we & owner_req;
    end
  end

  assign m0_data_in = (tag_valid_q && !tag_who_q) ? bus_data_in : '0;
  assign m1_data_in = (tag_valid_q &&  tag_who_q) ? bus_data_in : '0;

endmodule

// File: tb/tb_reflet_bus_arbiter16.sv
module tb_reflet_bus_arbiter16;

  localparam logic [15:0] A0 = 16'h0100;
  localparam logic [15:0] A1 = 16'h0200;
  localparam logic [15:0] BD = 16'hA000;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_write_en, m1_write_en;
  logic [15:0] m0_addr, m1_addr, m0_data_out, m1_data_out;
  logic        m0_gnt, m1_gnt, bus_write_en, bus_owner;
  logic [15:0] m0_data_in, m1_data_in, bus_addr, bus_data_out, bus_data_in;
`ifdef REFLET_ARBITER_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  reflet_bus_arbiter16 #(.wordsize(16), .burst_max(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_addr      (m0_addr),
    .m0_data_out  (m0_data_out),
    .m0_write_en  (m0_write_en),
    .m1_req       (m1_req),
    .m1_addr      (m1_addr),
    .m1_data_out  (m1_data_out),
    .m1_write_en  (m1_write_en),
`ifdef REFLET_ARBITER_LOCK_EN
    .m0_lock      (m0_lock),
    .m1_lock      (m1_lock),
`endif
    .m0_gnt       (m0_gnt),
    .m1_gnt       (m1_gnt),
    .m0_data_in   (m0_data_in),
    .m1_data_in   (m1_data_in),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_write_en (bus_write_en),
    .bus_data_in  (bus_data_in),
    .bus_owner    (bus_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        g0, g1, own;
    logic [15:0] addr, dout;
    logic        we;
    logic [15:0] d0, d1;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic g0, input logic g1, input logic own,
                     input logic [15:0] addr, input logic [15:0] dout, input logic we,
                     input logic [15:0] d0, input logic [15:0] d1);
    exp_t e;
    e.name = nm; e.g0 = g0; e.g1 = g1; e.own = own; e.addr = addr; e.dout = dout;
    e.we = we; e.d0 = d0; e.d1 = d1;
    sb.push_back(e);
  endtask

  task automatic chk0(input string nm);
    chk(nm, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
  endtask

  task automatic set_m0(input logic r, input logic [15:0] a, input logic [15:0] d,
                        input logic w);
    m0_req = r; m0_addr = a; m0_data_out = d; m0_write_en = w;
  endtask

  task automatic set_m1(input logic r, input logic [15:0] a, input logic [15:0] d,
                        input logic w);
    m1_req = r; m1_addr = a; m1_data_out = d; m1_write_en = w;
  endtask

  // Monitor: compares every DUT cycle that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({m0_gnt, m1_gnt, bus_owner, bus_addr, bus_data_out, bus_write_en,
             m0_data_in, m1_data_in} !==
            {e.g0, e.g1, e.own, e.addr, e.dout, e.we, e.d0, e.d1}) begin
          n_bad++;
          $display("FAIL %s: got g0=%b g1=%b own=%b addr=%h dout=%h we=%b d0=%h d1=%h, want g0=%b g1=%b own=%b addr=%h dout=%h we=%b d0=%h d1=%h",
                   e.name, m0_gnt, m1_gnt, bus_owner, bus_addr, bus_data_out, bus_write_en,
                   m0_data_in, m1_data_in, e.g0, e.g1, e.own, e.addr, e.dout, e.we, e.d0,
                   e.d1);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_m0(0, 16'h0, 16'h0, 0);
    set_m1(0, 16'h0, 16'h0, 0);
    bus_data_in = 16'h0;
`ifdef REFLET_ARBITER_LOCK_EN
    m0_lock = 1'b0;
    m1_lock = 1'b0;
`endif

    // Reset, then reset again while m0's read of 0x8000 is in flight.
    tick; chk0("reset");
    tick; reset = 1'b0; set_m0(1, 16'h8000, 16'h0, 0); chk0("idle_req");
    tick; bus_data_in = 16'h5555; chk("rd8000_gnt", 1, 0, 0, 16'h8000, 16'h0, 0, 16'h0, 16'h0);
    tick; reset = 1'b1; chk0("reset_mid_read");
    tick; reset = 1'b0; set_m0(0, 16'h0, 16'h0, 0); chk0("post_reset0");
    tick; chk0("post_reset1");

    // m0 alone reads 0x8002.
    tick; set_m0(1, 16'h8002, 16'h0, 0); bus_data_in = 16'h0; chk0("rd8002_req");
    tick; chk("rd8002_gnt", 1, 0, 0, 16'h8002, 16'h0, 0, 16'h0, 16'h0);
    tick; set_m0(0, 16'h0, 16'h0, 0); bus_data_in = 16'h1234;
    chk("rd8002_data", 1, 0, 0, 16'h0, 16'h0, 0, 16'h1234, 16'h0);
    tick; chk0("rd8002_release");

    // m1 writes 0xBEEF to 0xFF08.
    tick; set_m1(1, 16'hFF08, 16'hBEEF, 1); bus_data_in = 16'h0; chk0("wr_req");
    tick; chk("wr_strobe", 0, 1, 1, 16'hFF08, 16'hBEEF, 1, 16'h0, 16'h0);
    tick; set_m1(0, 16'h0, 16'h0, 0); chk("wr_tail", 0, 1, 1, 16'h0, 16'h0, 0, 16'h0, 16'h0);
    tick; chk0("wr_release");

    // Both request continuously from a fresh reset: 4-transfer slices, m0 first.
    tick; reset = 1'b1; chk0("reset2");
    tick; reset = 1'b0; set_m0(1, A0, 16'h0, 0); set_m1(1, A1, 16'h0, 0); bus_data_in = BD;
    chk0("both_req");
    tick; chk("rr_m0_first", 1, 0, 0, A0, 16'h0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick; chk("rr_m0_slice", 1, 0, 0, A0, 16'h0, 0, BD, 16'h0);
    end
    tick; chk("rr_m1_first", 0, 1, 1, A1, 16'h0, 0, BD, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick; chk("rr_m1_slice", 0, 1, 1, A1, 16'h0, 0, 16'h0, BD);
    end
    tick; chk("rr_m0_again", 1, 0, 0, A0, 16'h0, 0, 16'h0, BD);
    tick; chk("rr_m0_xfer1", 1, 0, 0, A0, 16'h0, 0, BD, 16'h0);

    // m0 drops req after 2 transfers; m1 takes over and gets a full fresh slice.
    tick; m0_req = 1'b0; chk("drop_m0", 1, 0, 0, A0, 16'h0, 0, BD, 16'h0);
    tick; m0_req = 1'b1; chk("handover_m1", 0, 1, 1, A1, 16'h0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick; chk("m1_fresh_slice", 0, 1, 1, A1, 16'h0, 0, 16'h0, BD);
    end
    tick; m0_req = 1'b0; m1_req = 1'b0;
    chk("back_to_m0", 1, 0, 0, A0, 16'h0, 0, 16'h0, BD);
    tick; chk0("all_idle");

`ifdef REFLET_ARBITER_LOCK_EN
    // m0 locks across 6 transfers while m1 waits.
    tick; set_m0(1, A0, 16'h0, 0); m0_lock = 1'b1; chk0("lock_req");
    tick; set_m1(1, A1, 16'h0, 0); chk("lock_gnt", 1, 0, 0, A0, 16'h0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick; chk("lock_hold", 1, 0, 0, A0, 16'h0, 0, BD, 16'h0);
    end
    tick; m0_lock = 1'b0; chk("lock_fall", 1, 0, 0, A0, 16'h0, 0, BD, 16'h0);
    tick; set_m0(0, A0, 16'h0, 0); set_m1(0, A1, 16'h0, 0);
    chk("lock_handover", 0, 1, 1, A1, 16'h0, 0, BD, 16'h0);
    tick; chk0("lock_idle");
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
